// File: rtl/raster_cmd_sched_pkg.sv
// raster_pkg: shared definitions for the rasterizer command path.
//   - command encodings (NOP/PIXEL/LINE/RECT) and the CLEAR coordinate
//   - 20-bit packed command layout {cmd, x1, y1, x2, y2, width, height}
//     with field offsets
//   - scheduler state encoding
//   - default rasterizer scan-out length
package raster_pkg;

    localparam int unsigned CMD_W       = 20;
    localparam int unsigned COORD_W     = 3;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned SCAN_CYCLES = 64;

    // A PIXEL command at (7,7) is treated as CLEAR by the rasterizer itself.
    localparam logic [COORD_W-1:0] CLEAR_COORD = 3'd7;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_PIXEL = 2'b01,
        CMD_LINE  = 2'b10,
        CMD_RECT  = 2'b11
    } cmd_e;

    localparam int unsigned OFS_HEIGHT = 0;
    localparam int unsigned OFS_WIDTH  = 3;
    localparam int unsigned OFS_Y2     = 6;
    localparam int unsigned OFS_X2     = 9;
    localparam int unsigned OFS_Y1     = 12;
    localparam int unsigned OFS_X1     = 15;
    localparam int unsigned OFS_CMD    = 18;

    typedef struct packed {
        logic [1:0]         cmd;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_DRAIN     = 3'd4
    } sched_state_e;

endpackage

// File: rtl/raster_cmd_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req   : request vector, one bit per requester
//   i_ptr   : requester with top priority; priority wraps upward from it
//   o_grant : one-hot grant (zero when nothing requests)
//   o_idx   : index of the granted requester
//   o_any   : at least one request present
module rr_arbiter
    import raster_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_best;
    int w_dist;

    // Each requester's distance from the pointer (mod N_REQ) is its rank;
    // the smallest-ranked active requester wins.
    always_comb begin
        w_best = N_REQ;
        w_dist = 0;
        o_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - (int'(i_ptr) % N_REQ)) % N_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_W'(i);
            end
        end
        o_any = (w_best < N_REQ);
        for (int i = 0; i < N_REQ; i++) begin
            o_grant[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/raster_cmd_sched.sv
// raster_cmd_sched: shares the 8x8 rasterizer between N_REQ requesters.
// One command at a time is accepted (round-robin), held on the out_* bus,
// started with a one-cycle cmd_ready, and the block then tracks the
// rasterizer through WAIT (frame_sync) and the scan-out before going idle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/req_cmd per-requester valid and packed 20-bit command
//   req_ready         combinational one-hot accept, only while idle
//   out_cmd, out_x1.. registered command bus, stable until next accept
//   cmd_ready         one-cycle start pulse to the rasterizer
//   frame_sync        rasterizer scan-out start (ignored unless waiting)
//   busy              high whenever not idle
//   grant_id          requester owning the current/last command
//   frame_done        one-cycle pulse on the first idle cycle after a frame
//   wdog_err          sticky timeout flag
//
// Build option: define RASTER_SCHED_WDOG_EN to bound the wait for
// frame_sync to WDOG_LIMIT cycles; otherwise the wait is unbounded and
// wdog_err is constant 0.
module raster_cmd_sched #(
    parameter int N_REQ       = 2,
    parameter int SCAN_CYCLES = raster_pkg::SCAN_CYCLES,
    parameter int WDOG_LIMIT  = 15
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*raster_pkg::CMD_W-1:0] req_cmd,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [1:0]                         out_cmd,
    output logic [2:0]                         out_x1,
    output logic [2:0]                         out_y1,
    output logic [2:0]                         out_x2,
    output logic [2:0]                         out_y2,
    output logic [2:0]                         out_width,
    output logic [2:0]                         out_height,
    output logic                               cmd_ready,
    input  logic                               frame_sync,
    output logic                               busy,
    output logic [1:0]                         grant_id,
    output logic                               frame_done,
    output logic                               wdog_err
);

    import raster_pkg::*;

    localparam int CNT_W = $clog2(SCAN_CYCLES);

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant_id;
    logic             r_frame_done;
    cmd_t             r_bus;

    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_any;
    cmd_t             w_win_cmd;
    logic             w_accept;
    logic             w_frame_done_nxt;

`ifdef RASTER_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    logic [WD_W-1:0] r_wdog_cnt;
    logic            r_wdog_err;
    logic            w_wdog_fire;
`else
    // The limit only matters with the watchdog built in.
    if (WDOG_LIMIT < 1) begin : g_wdog_limit_unused
    end
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req  (req_valid),
        .i_ptr  (r_rr_ptr),
        .o_grant(w_grant),
        .o_idx  (w_win_idx),
        .o_any  (w_win_any)
    );

    always_comb begin
        w_win_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_cmd = cmd_t'(req_cmd[i*CMD_W +: CMD_W]);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        w_frame_done_nxt = 1'b0;
        req_ready        = '0;
        cmd_ready        = 1'b0;
`ifdef RASTER_SCHED_WDOG_EN
        w_wdog_fire      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                if (w_win_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_ready   = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_state_nxt = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                // A sync arriving on the last allowed cycle still wins.
                if (frame_sync) begin
                    w_state_nxt = ST_DRAIN;
                end
`ifdef RASTER_SCHED_WDOG_EN
                else if (r_wdog_cnt == WD_W'(WDOG_LIMIT - 1)) begin
                    w_state_nxt      = ST_IDLE;
                    w_frame_done_nxt = 1'b1;
                    w_wdog_fire      = 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                // Counting 0..SCAN_CYCLES-2 covers the remaining scan-out;
                // the sync cycle itself was the first one.
                if (r_drain_cnt == CNT_W'(SCAN_CYCLES - 2)) begin
                    w_state_nxt      = ST_IDLE;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_frame_done <= 1'b0;
            r_drain_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (w_accept) begin
                r_grant_id <= w_win_idx;
                r_rr_ptr   <= (w_win_idx == IDX_W'(N_REQ - 1)) ? '0 : w_win_idx + 2'd1;
            end
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // Bus is captured only at acceptance so it stays put for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus <= '0;
        end else if (w_accept) begin
            r_bus <= w_win_cmd;
        end
    end

`ifdef RASTER_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_SYNC) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end else begin
                r_wdog_cnt <= '0;
            end
            if (w_wdog_fire) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign wdog_err = 1'b0;
`endif

    assign busy       = (r_state != ST_IDLE);
    assign grant_id   = r_grant_id;
    assign frame_done = r_frame_done;
    assign out_cmd    = r_bus.cmd;
    assign out_x1     = r_bus.x1;
    assign out_y1     = r_bus.y1;
    assign out_x2     = r_bus.x2;
    assign out_y2     = r_bus.y2;
    assign out_width  = r_bus.width;
    assign out_height = r_bus.height;

endmodule

// File: tb/tb_raster_cmd_sched.sv
`timescale 1ns/1ps
module tb_raster_cmd_sched;
    localparam int N    = 3;
    localparam int SCAN = 64;
    localparam int WL   = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*20-1:0] req_cmd;
    logic [N-1:0]    req_ready;
    logic [1:0]      out_cmd;
    logic [2:0]      out_x1, out_y1, out_x2, out_y2, out_width, out_height;
    logic            cmd_ready, frame_sync, busy, frame_done, wdog_err;
    logic [1:0]      grant_id;

    raster_cmd_sched #(.N_REQ(N), .SCAN_CYCLES(SCAN), .WDOG_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .out_cmd(out_cmd), .out_x1(out_x1), .out_y1(out_y1),
        .out_x2(out_x2), .out_y2(out_y2), .out_width(out_width), .out_height(out_height),
        .cmd_ready(cmd_ready), .frame_sync(frame_sync), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    // cycle c = the period following the c-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: a command accepted in cycle a issues at a+1, waits
    // for sync from a+3, drains 63 cycles after the sync cycle, idles after.
    bit          m_idle = 1'b1;
    int          m_acc  = -100;
    int          m_sync = -1;
    int          m_ptr  = 0;
    int          m_grant = 0;
    bit          m_wdog = 1'b0;
    logic [19:0] m_bus  = '0;

    // Rasterizer stand-in and stimulus knobs
    int sync_at   = -1;
    int max_delay = 0;
    int drop_pct  = 0;
    int spur_div  = 0;
    logic [N-1:0]    d_valid = '0;
    logic [N*20-1:0] d_cmd   = '0;

    int n_chk = 0, n_err = 0, n_acc = 0;
    int issue_q[$];
    int grant_q[$];
    int last_fd = -1, last_acc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -9999;
    endfunction

    task automatic step();
        bit exp_fd;
        bit waiting;
        int win;
        @(negedge clk);
        exp_fd = 1'b0;
        if (!m_idle) begin
            if (m_sync >= 0 && cyc == m_sync + SCAN - 1) begin
                m_idle = 1'b1; exp_fd = 1'b1;
            end
`ifdef RASTER_SCHED_WDOG_EN
            else if (m_sync < 0 && cyc == m_acc + 3 + WL) begin
                m_idle = 1'b1; exp_fd = 1'b1; m_wdog = 1'b1;
            end
`endif
        end
        chk("busy", busy, !m_idle);
        chk("cmd_ready", cmd_ready, (!m_idle && cyc == m_acc + 1));
        chk("frame_done", frame_done, exp_fd);
        chk("grant_id", grant_id, m_grant);
        chk("out_bus", {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height}, m_bus);
        chk("wdog_err", wdog_err, m_wdog);
        if (cmd_ready === 1'b1) begin
            issue_q.push_back(cyc);
            grant_q.push_back(int'(grant_id));
        end
        if (frame_done === 1'b1) last_fd = cyc;

        waiting   = !m_idle && m_sync < 0 && cyc >= m_acc + 3;
        req_valid = d_valid;
        req_cmd   = d_cmd;
        frame_sync = (cyc == sync_at) ||
                     (!waiting && spur_div > 0 && $urandom_range(spur_div - 1) == 0);
        #1;
        win = -1;
        if (m_idle) begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (m_ptr + k) % N;
                if (win < 0 && d_valid[r]) win = r;
            end
        end
        chk("req_ready", req_ready, (win >= 0) ? (1 << win) : 0);
        if (win >= 0) begin
            m_idle = 1'b0; m_acc = cyc; m_sync = -1; m_grant = win;
            m_ptr = (win + 1) % N;
            m_bus = d_cmd[win*20 +: 20];
            last_acc = cyc;
            n_acc++;
            sync_at = ($urandom_range(99) < drop_pct) ? -1 :
                      cyc + 4 + ((max_delay > 0) ? $urandom_range(max_delay) : 0);
        end else if (waiting && frame_sync) begin
            m_sync = cyc + 1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; frame_sync = 1'b0; d_valid = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_wdog_err", wdog_err, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_bus", {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_idle = 1'b1; m_acc = -100; m_sync = -1; m_ptr = 0; m_grant = 0;
        m_wdog = 1'b0; m_bus = '0; sync_at = -1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) d_cmd[i*20 +: 20] = 20'($urandom());
    endtask

    initial begin
        int a0;
        bit found;
        rst_n = 1'b1; req_valid = '0; req_cmd = '0; frame_sync = 1'b0;
        #1;
        do_reset();

        // Single PIXEL (3,5) from requester 0
        d_cmd = '0;
        d_cmd[19:0] = {2'b01, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
        d_valid = 3'b001;
        step();
        d_valid = '0;
        a0 = last_acc;
        issue_q.delete();
        repeat (80) step();
        chk("single_accepted", a0 >= 0, 1);
        chk("single_issue_count", issue_q.size(), 1);
        chk("single_issue_lat", qget(issue_q, 0) - a0, 1);
        chk("single_done_lat", last_fd - a0, 68);
        chk("single_bus", {out_cmd, out_x1, out_y1}, {2'b01, 3'd3, 3'd5});

        // Contention: 0 and 1 always valid, payload churns while waiting
        do_reset();
        issue_q.delete(); grant_q.delete();
        spur_div = 16;
        d_valid = 3'b011;
        for (int i = 0; i < 4 * 68 + 4; i++) begin
            rand_payload();
            step();
        end
        d_valid = '0;
        repeat (70) step();
        chk("cont_grant0", qget(grant_q, 0), 0);
        chk("cont_grant1", qget(grant_q, 1), 1);
        chk("cont_grant2", qget(grant_q, 2), 0);
        chk("cont_grant3", qget(grant_q, 3), 1);
        for (int i = 0; i < 3; i++)
            chk("cont_issue_gap", qget(issue_q, i + 1) - qget(issue_q, i), 68);

        // Reset during DRAIN cycle 20, then normal timing again
        spur_div = 0;
        rand_payload();
        d_valid = 3'b100;
        step();
        d_valid = '0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = (m_sync >= 0 && cyc == m_sync + 20);
        end
        chk("reached_drain20", found, 1);
        do_reset();
        rand_payload();
        d_valid = 3'b010;
        step();
        d_valid = '0;
        a0 = last_acc;
        issue_q.delete(); grant_q.delete();
        repeat (75) step();
        chk("post_rst_grant", qget(grant_q, 0), 1);
        chk("post_rst_issue_lat", qget(issue_q, 0) - a0, 1);
        chk("post_rst_done_lat", last_fd - a0, 68);

        // Randomized traffic
        max_delay = 6;
        spur_div  = 20;
`ifdef RASTER_SCHED_WDOG_EN
        drop_pct = 25;
`endif
        n_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++) d_valid[r] = ($urandom_range(4) < 2);
            rand_payload();
            step();
        end
        chk("rand_accepts_seen", n_acc > 20, 1);

`ifdef RASTER_SCHED_WDOG_EN
        // Watchdog: no sync at all, then a normal command
        do_reset();
        max_delay = 0; spur_div = 0; drop_pct = 100;
        rand_payload();
        d_valid = 3'b001;
        step();
        d_valid = '0;
        drop_pct = 0;
        a0 = last_acc;
        repeat (25) step();
        chk("wdog_flag", wdog_err, 1);
        chk("wdog_done_lat", last_fd - a0, 18);
        rand_payload();
        d_valid = 3'b010;
        step();
        d_valid = '0;
        a0 = last_acc;
        repeat (75) step();
        chk("wdog_next_grant", grant_id, 1);
        chk("wdog_next_done_lat", last_fd - a0, 68);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
